// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI4 read channel between the ICache and DCache ports: round-robin
// grant, one AR burst in flight, R beats packed into a line returned with a pulse.
module cache_axi_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned LINE_W = 128,
  parameter logic [3:0]  IC_ID  = 4'd0,
  parameter logic [3:0]  DC_ID  = 4'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_rd_req,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  input  logic [7:0]        ic_rd_len,
  output logic              ic_ret_valid,
  output logic [LINE_W-1:0] ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  input  logic [7:0]        dc_rd_len,
  output logic              dc_ret_valid,
  output logic [LINE_W-1:0] dc_ret_data,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [BEAT_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int unsigned WORDS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, AR, R, RET} state_t;

  state_t            state, state_nx;
  logic              grant, grant_nx;          // 0 = ICache, 1 = DCache
  logic              last_grant, last_grant_nx;
  logic              cancel, cancel_nx;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nx;
  logic [LINE_W-1:0] line_buf, line_buf_nx;
  logic [LINE_W-1:0] ret_data, ret_data_nx;
  logic [3:0]        arid_nx;
  logic [ADDR_W-1:0] araddr_nx;
  logic [7:0]        arlen_nx;
  logic              arvalid_nx, rready_nx;
  logic              ic_ret_valid_nx, dc_ret_valid_nx;
  logic              granted_req;
  logic              unused_rresp;

  assign arsize       = 3'b010;
  assign arburst      = 2'b01;
  assign ic_ret_data  = ret_data;
  assign dc_ret_data  = ret_data;
  assign unused_rresp = ^rresp;

  always_comb begin
    granted_req = grant ? dc_rd_req : ic_rd_req;
  end

  // Next-state and registered-output values
  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    cancel_nx     = cancel;
    beat_cnt_nx   = beat_cnt;
    line_buf_nx   = line_buf;
    arid_nx       = arid;
    araddr_nx     = araddr;
    arlen_nx      = arlen;

    case (state)
      IDLE: begin
        if (ic_rd_req || dc_rd_req) begin
          grant_nx    = (ic_rd_req && dc_rd_req) ? ~last_grant : dc_rd_req;
          arid_nx     = grant_nx ? DC_ID : IC_ID;
          araddr_nx   = grant_nx ? dc_rd_addr : ic_rd_addr;
          arlen_nx    = grant_nx ? dc_rd_len : ic_rd_len;
          beat_cnt_nx = '0;
          cancel_nx   = 1'b0;
          line_buf_nx = '0;
          state_nx    = AR;
        end
      end
      AR: begin
        if (!granted_req) cancel_nx = 1'b1;
        if (arvalid && arready) state_nx = R;
      end
      R: begin
        if (!granted_req) cancel_nx = 1'b1;
        if (rvalid) begin
          line_buf_nx[32'(beat_cnt) * BEAT_W +: BEAT_W] = rdata;
          beat_cnt_nx = beat_cnt + CNT_W'(1);
          if (rlast) state_nx = RET;
        end
      end
      RET: begin
        last_grant_nx = grant;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Outputs are registered from the state being entered
    arvalid_nx      = (state_nx == AR);
    rready_nx       = (state_nx == R);
    ic_ret_valid_nx = (state_nx == RET) && !cancel_nx && !grant_nx;
    dc_ret_valid_nx = (state_nx == RET) && !cancel_nx && grant_nx;
    ret_data_nx     = (state_nx == RET) ? line_buf_nx : ret_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b0;
      cancel       <= 1'b0;
      beat_cnt     <= '0;
      line_buf     <= '0;
      ret_data     <= '0;
      arid         <= '0;
      araddr       <= '0;
      arlen        <= '0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      ic_ret_valid <= 1'b0;
      dc_ret_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      grant        <= grant_nx;
      last_grant   <= last_grant_nx;
      cancel       <= cancel_nx;
      beat_cnt     <= beat_cnt_nx;
      line_buf     <= line_buf_nx;
      ret_data     <= ret_data_nx;
      arid         <= arid_nx;
      araddr       <= araddr_nx;
      arlen        <= arlen_nx;
      arvalid      <= arvalid_nx;
      rready       <= rready_nx;
      ic_ret_valid <= ic_ret_valid_nx;
      dc_ret_valid <= dc_ret_valid_nx;
    end
  end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed bench for cache_axi_rd_arbiter: transaction-level model compared every
// cycle, plus literal expectations for each scenario.
module tb_cache_axi_rd_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_rd_req, dc_rd_req;
  logic [31:0]  ic_rd_addr, dc_rd_addr;
  logic [7:0]   ic_rd_len, dc_rd_len;
  logic         ic_ret_valid, dc_ret_valid;
  logic [127:0] ic_ret_data, dc_ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;

  int n_checks = 0;
  int n_fail   = 0;

  cache_axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_len(ic_rd_len),
    .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_len(dc_rd_len),
    .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 waiting, 1 address, 2 data, 3 return
  int          m_ph = 0;
  int          m_owner = 0;  // 0 = ICache, 1 = DCache
  int          m_last = 0;
  int          m_cnt = 0;
  bit          m_cancel = 0;
  bit          m_rst = 0;
  logic [31:0] m_words [4];
  logic [31:0] m_addr = '0;
  logic [7:0]  m_len = '0;
  logic [3:0]  m_id = '0;

  always @(posedge clk) begin
    bit owner_req;
    m_rst = rst;
    if (rst) begin
      m_ph = 0; m_last = 0; m_cancel = 0; m_cnt = 0;
      m_addr = '0; m_len = '0; m_id = '0;
    end else begin
      owner_req = (m_owner == 1) ? dc_rd_req : ic_rd_req;
      case (m_ph)
        0: if (ic_rd_req || dc_rd_req) begin
             if (ic_rd_req && dc_rd_req) m_owner = 1 - m_last;
             else m_owner = dc_rd_req ? 1 : 0;
             m_id   = (m_owner == 1) ? 4'd1 : 4'd0;
             m_addr = (m_owner == 1) ? dc_rd_addr : ic_rd_addr;
             m_len  = (m_owner == 1) ? dc_rd_len : ic_rd_len;
             for (int i = 0; i < 4; i++) m_words[i] = '0;
             m_cnt = 0; m_cancel = 0; m_ph = 1;
           end
        1: begin
             if (!owner_req) m_cancel = 1;
             if (arready) m_ph = 2;
           end
        2: begin
             if (!owner_req) m_cancel = 1;
             if (rvalid) begin
               m_words[m_cnt % 4] = rdata;
               m_cnt++;
               if (rlast) m_ph = 3;
             end
           end
        default: begin m_last = m_owner; m_ph = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [127:0] line;
    line = {m_words[3], m_words[2], m_words[1], m_words[0]};
    chk("arvalid", arvalid, m_ph == 1);
    chk("rready", rready, m_ph == 2);
    chk("ic_ret_valid", ic_ret_valid, m_ph == 3 && m_owner == 0 && !m_cancel);
    chk("dc_ret_valid", dc_ret_valid, m_ph == 3 && m_owner == 1 && !m_cancel);
    chk("arid", arid, m_id);
    chk("araddr", araddr, m_addr);
    chk("arlen", arlen, m_len);
    chk("arsize", arsize, 3'b010);
    chk("arburst", arburst, 2'b01);
    if (m_ph == 3) begin
      chk("ret_data_ic", ic_ret_data, line);
      chk("ret_data_dc", dc_ret_data, line);
    end else if (m_rst) begin
      chk("ret_data_rst", ic_ret_data, 128'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_arvalid();
    int t = 0;
    while (!arvalid && t < 50) begin tick(); t++; end
    if (!arvalid) begin
      n_checks++; n_fail++;
      $display("FAIL arvalid_timeout: got 0 expected 1 at %0t", $time);
    end
  endtask

  // Acts as AXI slave for one burst; returns in the RET cycle
  task automatic serve(input int n, input logic [31:0] base, input int ar_wait,
                       input bit gap, input bit drop_ic, output logic [3:0] id_seen);
    wait_arvalid();
    id_seen = arid;
    repeat (ar_wait) tick();
    arready = 1'b1; tick(); arready = 1'b0;
    if (drop_ic) ic_rd_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gap) begin rvalid = 1'b0; tick(); end
      rvalid = 1'b1; rdata = base + 32'(i); rlast = (i == n - 1);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  logic [3:0] id;
  logic [3:0] ids [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ic_rd_req = 0; dc_rd_req = 0; ic_rd_addr = '0; dc_rd_addr = '0;
    ic_rd_len = '0; dc_rd_len = '0; arready = 0; rdata = '0; rresp = 2'b10;
    rlast = 0; rvalid = 0;
    repeat (3) tick();
    chk("reset_arvalid", arvalid, 1'b0);
    chk("reset_ret_data", ic_ret_data, 128'h0);
    rst = 1'b0;
    tick();

    // 1: ICache line fill
    ic_rd_req = 1; ic_rd_addr = 32'h1FC0_0010; ic_rd_len = 8'd3;
    tick();
    chk("t1_araddr", araddr, 32'h1FC0_0010);
    chk("t1_arlen", arlen, 8'd3);
    serve(4, 32'hA0, 0, 0, 0, id);
    chk("t1_arid", id, 4'd0);
    chk("t1_ic_ret_valid", ic_ret_valid, 1'b1);
    chk("t1_dc_ret_valid", dc_ret_valid, 1'b0);
    chk("t1_data", ic_ret_data, 128'h000000A3_000000A2_000000A1_000000A0);
    ic_rd_req = 0;
    tick();

    // 2: simultaneous requests alternate, DCache first
    for (int r = 0; r < 2; r++) begin
      ic_rd_req = 1; ic_rd_addr = 32'h1FC0_1000; ic_rd_len = 8'd3;
      dc_rd_req = 1; dc_rd_addr = 32'h8000_1000; dc_rd_len = 8'd3;
      serve(4, 32'hB0, 0, 0, 0, ids[2*r]);
      chk("t2_dc_ret_valid", dc_ret_valid, 1'b1);
      chk("t2_ic_quiet", ic_ret_valid, 1'b0);
      chk("t2_dc_data", dc_ret_data, 128'h000000B3_000000B2_000000B1_000000B0);
      dc_rd_req = 0;
      serve(4, 32'hC0, 0, 0, 0, ids[2*r+1]);
      chk("t2_ic_ret_valid", ic_ret_valid, 1'b1);
      ic_rd_req = 0;
      tick();
    end
    chk("t2_id0", ids[0], 4'd1);
    chk("t2_id1", ids[1], 4'd0);
    chk("t2_id2", ids[2], 4'd1);
    chk("t2_id3", ids[3], 4'd0);

    // 3: uncached single word
    ic_rd_req = 1; ic_rd_addr = 32'h1FC0_0100; ic_rd_len = 8'd0;
    serve(1, 32'hDEADBEEF, 0, 0, 0, id);
    chk("t3_ic_ret_valid", ic_ret_valid, 1'b1);
    chk("t3_data", ic_ret_data, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    ic_rd_req = 0;
    tick();

    // 4: slow AR and gapped R
    dc_rd_req = 1; dc_rd_addr = 32'h8000_0040; dc_rd_len = 8'd3;
    serve(4, 32'hD0, 5, 1, 0, id);
    chk("t4_dc_ret_valid", dc_ret_valid, 1'b1);
    chk("t4_data", dc_ret_data, 128'h000000D3_000000D2_000000D1_000000D0);
    dc_rd_req = 0;
    tick();

    // 5: ICache flushes mid-burst while DCache waits
    ic_rd_req = 1; ic_rd_addr = 32'h1FC0_0200; ic_rd_len = 8'd3;
    tick();
    dc_rd_req = 1; dc_rd_addr = 32'h8000_0080; dc_rd_len = 8'd3;
    serve(4, 32'h50, 0, 0, 1, id);
    chk("t5_ic_suppressed", ic_ret_valid, 1'b0);
    chk("t5_dc_quiet", dc_ret_valid, 1'b0);
    tick();
    chk("t5_idle_arvalid", arvalid, 1'b0);
    tick();
    chk("t5_dc_arvalid", arvalid, 1'b1);
    chk("t5_dc_arid", arid, 4'd1);
    serve(4, 32'hE0, 0, 0, 0, id);
    chk("t5_dc_data", dc_ret_data, 128'h000000E3_000000E2_000000E1_000000E0);
    dc_rd_req = 0;
    tick();

    // 6: reset mid-burst then a fresh request
    ic_rd_req = 1; ic_rd_addr = 32'h1FC0_0300; ic_rd_len = 8'd3;
    wait_arvalid();
    arready = 1; tick(); arready = 0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1; rdata = 32'h70 + 32'(i); tick();
    end
    rvalid = 0; rst = 1; ic_rd_req = 0;
    tick();
    chk("t6_arvalid", arvalid, 1'b0);
    chk("t6_rready", rready, 1'b0);
    chk("t6_araddr", araddr, 32'h0);
    chk("t6_arlen", arlen, 8'h0);
    chk("t6_ret_data", ic_ret_data, 128'h0);
    rst = 0;
    tick();
    ic_rd_req = 1; ic_rd_addr = 32'h1FC0_0400; ic_rd_len = 8'd3;
    serve(4, 32'hF0, 0, 0, 0, id);
    chk("t6_ic_ret_valid", ic_ret_valid, 1'b1);
    chk("t6_data", ic_ret_data, 128'h000000F3_000000F2_000000F1_000000F0);
    ic_rd_req = 0;
    tick();

    // 7: six beats wrap the word index
    dc_rd_req = 1; dc_rd_addr = 32'h8000_0100; dc_rd_len = 8'd5;
    serve(6, 32'h10, 0, 0, 0, id);
    chk("t7_dc_ret_valid", dc_ret_valid, 1'b1);
    chk("t7_data", dc_ret_data, 128'h00000013_00000012_00000015_00000014);
    dc_rd_req = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
